control_fsm: RTL and testbench

//  Multi-cycle main control FSM for the 64-bit LEGv8-subset datapath; drives the ALU op code (aluOP) and consumes the ALU zero flag.

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/control_fsm_if.sv | 35 +++
 rtl/control_fsm_opcode_decode.sv | 43 ++++
 rtl/control_fsm.sv | 157 +++++++++++++++
 tb/tb_control_fsm.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control FSM:
// ALU ops, operand-B selects, opcode patterns, states and fault codes.
package ctrl_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ_HI  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ_HI = 8'b10110101;
    localparam logic [5:0]  OP_B_HI    = 6'b000101;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_MEM,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_LD,
        S_BR_CBZ,
        S_BR_B,
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_LD,
        CLS_ST,
        CLS_CBZ,
        CLS_CBNZ,
        CLS_B,
        CLS_ILL
    } iclass_e;

    // Classes whose register-B port must read Rt instead of Rm
    function automatic logic uses_rt(input iclass_e c);
        return (c == CLS_ST) || (c == CLS_CBZ) || (c == CLS_CBNZ);
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
interface control_fsm_if;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic [2:0]  aluOP;
    logic        alu_srcA;
    logic [1:0]  alu_srcB;
    logic        reg2loc;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        fault;
    logic [1:0]  fault_code;

    modport master (
        input  opcode, zero, mem_ready,
        output aluOP, alu_srcA, alu_srcB, reg2loc,
        output ir_write, pc_write, pc_src,
        output mem_read, mem_write, reg_write, mem_to_reg,
        output fault, fault_code
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  aluOP, alu_srcA, alu_srcB, reg2loc,
        input  ir_write, pc_write, pc_src,
        input  mem_read, mem_write, reg_write, mem_to_reg,
        input  fault, fault_code
    );
endinterface

// File: rtl/control_fsm_opcode_decode.sv
// Combinational opcode -> instruction class and R-type ALU op.
// CBNZ is recognised only when CTRL_CBNZ_EN is defined.
module opcode_decode
    import ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output iclass_e     iclass,
    output logic [2:0]  r_alu_op
);

    always_comb begin
        iclass   = CLS_ILL;
        r_alu_op = ALU_ADD;
        case (opcode)
            OP_ADD:  iclass = CLS_R;
            OP_SUB: begin
                iclass   = CLS_R;
                r_alu_op = ALU_SUB;
            end
            OP_AND: begin
                iclass   = CLS_R;
                r_alu_op = ALU_AND;
            end
            OP_ORR: begin
                iclass   = CLS_R;
                r_alu_op = ALU_ORR;
            end
            OP_LDUR: iclass = CLS_LD;
            OP_STUR: iclass = CLS_ST;
            default: begin
                if (opcode[10:3] == OP_CBZ_HI)
                    iclass = CLS_CBZ;
`ifdef CTRL_CBNZ_EN
                else if (opcode[10:3] == OP_CBNZ_HI)
                    iclass = CLS_CBNZ;
`endif
                else if (opcode[10:5] == OP_B_HI)
                    iclass = CLS_B;
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle LEGv8 main control FSM with memory-wait timeout and trap.
// Optional CBNZ support via CTRL_CBNZ_EN.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    control_fsm_if.master bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e      state_q, state_d;
    logic [10:0] opcode_q, opcode_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [1:0]  fcode_q, fcode_d;

    logic [10:0] dec_op;
    iclass_e     iclass;
    logic [2:0]  r_alu_op;
    logic        wait_st;
    logic        tmo_hit;

    // DECODE sees the live IR; later states use the latched copy
    assign dec_op = (state_q == S_DECODE) ? bus.opcode : opcode_q;

    opcode_decode u_dec (
        .opcode   (dec_op),
        .iclass   (iclass),
        .r_alu_op (r_alu_op)
    );

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
    assign tmo_hit = wait_st && !bus.mem_ready &&
                     (tmo_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            tmo_q    <= '0;
            fcode_q  <= FC_NONE;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            tmo_q    <= tmo_d;
            fcode_q  <= fcode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        fcode_d  = fcode_q;
        tmo_d    = '0;

        bus.aluOP      = ALU_ADD;
        bus.alu_srcA   = 1'b0;
        bus.alu_srcB   = SRCB_REG;
        bus.reg2loc    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.fault      = 1'b0;
        bus.fault_code = fcode_q;

        if (wait_st && !bus.mem_ready)
            tmo_d = tmo_q + 1'b1;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_read = 1'b1;
                bus.alu_srcB = SRCB_FOUR;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
                if (bus.mem_ready)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_srcB = SRCB_BOFF;
                bus.reg2loc  = uses_rt(iclass);
                opcode_d     = bus.opcode;
                case (iclass)
                    CLS_R:            state_d = S_EXEC_R;
                    CLS_LD, CLS_ST:   state_d = S_EXEC_MEM;
                    CLS_CBZ, CLS_CBNZ: state_d = S_BR_CBZ;
                    CLS_B:            state_d = S_BR_B;
                    default: begin
                        state_d = S_TRAP;
                        fcode_d = FC_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: begin
                bus.alu_srcA = 1'b1;
                bus.aluOP    = r_alu_op;
                state_d      = S_WB_R;
            end
            S_WB_R: begin
                bus.aluOP     = r_alu_op;
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXEC_MEM: begin
                bus.alu_srcA = 1'b1;
                bus.alu_srcB = SRCB_IMM;
                state_d = (iclass == CLS_LD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready)
                    state_d = S_WB_LD;
            end
            S_WB_LD: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.reg2loc   = 1'b1;
                if (bus.mem_ready)
                    state_d = S_FETCH;
            end
            S_BR_CBZ: begin
                bus.reg2loc = 1'b1;
                bus.aluOP   = ALU_PASSB;
                bus.pc_src  = 1'b1;
                bus.pc_write = (iclass == CLS_CBNZ) ? !bus.zero : bus.zero;
                state_d     = S_FETCH;
            end
            S_BR_B: begin
                bus.pc_src   = 1'b1;
                bus.pc_write = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: bus.fault = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Ready in the limit cycle never reaches here, so it wins
        if (tmo_hit) begin
            state_d = S_TRAP;
            fcode_d = FC_TIMEOUT;
            tmo_d   = '0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-instruction expected-cycle model.
module tb_control_fsm;

    localparam int T = 16;

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] ANDI = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] CBNZ = 11'b10110101000;
    localparam logic [10:0] BR   = 11'b00010110110;
    localparam logic [10:0] ILL  = 11'b11111111111;

    localparam logic [8:0] R2L = 9'h100;
    localparam logic [8:0] IRW = 9'h080;
    localparam logic [8:0] PCW = 9'h040;
    localparam logic [8:0] PCS = 9'h020;
    localparam logic [8:0] MR  = 9'h010;
    localparam logic [8:0] MW  = 9'h008;
    localparam logic [8:0] RW  = 9'h004;
    localparam logic [8:0] M2R = 9'h002;
    localparam logic [8:0] FLT = 9'h001;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3;
    localparam int K_CBNZ = 4, K_B = 5, K_ILL = 6;

    typedef struct {
        logic        r;
        logic [10:0] op;
        logic        z;
        logic        rdy;
        logic [16:0] exp;
        string       tag;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    cyc_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   sc_rw, sc_mr, sc_pcw;

    control_fsm_if bus();

    control_fsm #(.TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] actual();
        return {bus.aluOP, bus.alu_srcA, bus.alu_srcB,
                bus.reg2loc, bus.ir_write, bus.pc_write, bus.pc_src,
                bus.mem_read, bus.mem_write, bus.reg_write,
                bus.mem_to_reg, bus.fault, bus.fault_code};
    endfunction

    function automatic logic [16:0] o(input logic [2:0] a,
                                      input logic sa,
                                      input logic [1:0] sb,
                                      input logic [8:0] f,
                                      input logic [1:0] fc);
        return {a, sa, sb, f, fc};
    endfunction

    function automatic int cls(input logic [10:0] op);
        if (op == ADD || op == SUB || op == ANDI || op == ORR) return K_R;
        if (op == LDUR) return K_LD;
        if (op == STUR) return K_ST;
        if (op[10:3] == 8'b10110100) return K_CBZ;
`ifdef CTRL_CBNZ_EN
        if (op[10:3] == 8'b10110101) return K_CBNZ;
`endif
        if (op[10:5] == 6'b000101) return K_B;
        return K_ILL;
    endfunction

    function automatic logic [2:0] ralu(input logic [10:0] op);
        if (op == SUB) return 3'b001;
        if (op == ANDI) return 3'b010;
        if (op == ORR) return 3'b011;
        return 3'b000;
    endfunction

    task automatic push(input logic r, input logic [10:0] op,
                        input logic z, input logic rdy,
                        input logic [16:0] e, input string t);
        cyc_t c;
        c.r = r; c.op = op; c.z = z; c.rdy = rdy; c.exp = e; c.tag = t;
        q.push_back(c);
    endtask

    task automatic push_reset();
        push(1'b1, '0, 1'b0, 1'b0, '0, "RESET");
        push(1'b0, '0, 1'b0, 1'b0, '0, "IDLE");
    endtask

    task automatic push_trap(input int n, input logic [10:0] op,
                             input logic [1:0] code);
        for (int i = 0; i < n; i++)
            push(1'b0, op, i[0], ~i[0], o(0, 0, 0, FLT, code), "TRAP");
    endtask

    // Expected cycle trace of one instruction, from fetch to retire/trap
    task automatic push_instr(input logic [10:0] op, input int fw,
                              input int mw, input logic z,
                              input int ntrap);
        int c;
        logic [8:0] f;
        for (int i = 0; i < fw && i < T; i++)
            push(0, op, z, 0, o(0, 0, 2'b01, MR, 0), "FETCH_W");
        if (fw >= T) begin
            push_trap(ntrap, op, 2'b10);
            return;
        end
        push(0, op, z, 1, o(0, 0, 2'b01, MR | IRW | PCW, 0), "FETCH");
        c = cls(op);
        f = (c == K_ST || c == K_CBZ || c == K_CBNZ) ? R2L : 9'h0;
        push(0, op, z, 1, o(0, 0, 2'b11, f, 0), "DECODE");
        case (c)
            K_R: begin
                push(0, op, z, 1, o(ralu(op), 1, 0, 0, 0), "EXEC_R");
                push(0, op, z, 1, o(ralu(op), 0, 0, RW, 0), "WB_R");
            end
            K_LD, K_ST: begin
                f = (c == K_LD) ? MR : (MW | R2L);
                push(0, op, z, 1, o(0, 1, 2'b10, 0, 0), "EXEC_MEM");
                for (int i = 0; i < mw && i < T; i++)
                    push(0, op, z, 0, o(0, 0, 0, f, 0), "MEM_W");
                if (mw >= T) begin
                    push_trap(ntrap, op, 2'b10);
                    return;
                end
                push(0, op, z, 1, o(0, 0, 0, f, 0), "MEM");
                if (c == K_LD)
                    push(0, op, z, 1, o(0, 0, 0, RW | M2R, 0), "WB_LD");
            end
            K_CBZ, K_CBNZ: begin
                f = R2L | PCS;
                if ((c == K_CBZ) ? z : !z) f = f | PCW;
                push(0, op, z, 1, o(3'b100, 0, 0, f, 0), "BR_CBZ");
            end
            K_B: push(0, op, z, 1, o(0, 0, 0, PCS | PCW, 0), "BR_B");
            default: push_trap(ntrap, op, 2'b01);
        endcase
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_q();
        cyc_t c;
        logic [16:0] act;
        sc_rw = 0; sc_mr = 0; sc_pcw = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            rst = c.r;
            bus.opcode = c.op;
            bus.zero = c.z;
            bus.mem_ready = c.rdy;
            #1;
            act = actual();
            checks++;
            if (act !== c.exp) begin
                failures++;
                $display("FAIL %s: got %05h expected %05h",
                         c.tag, act, c.exp);
            end
            if (bus.reg_write) sc_rw++;
            if (bus.mem_read) sc_mr++;
            if (bus.pc_write) sc_pcw++;
        end
    endtask

    initial begin
        bus.opcode = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        push_reset();
        run_q();

        push_instr(ADD, 0, 0, 0, 0);
        chk("add_len", q.size(), 4);
        run_q();
        chk("add_rw", sc_rw, 1);

        push_instr(SUB, 1, 0, 1, 0);
        push_instr(ANDI, 0, 0, 0, 0);
        push_instr(ORR, 2, 0, 1, 0);
        push_instr(BR, 0, 0, 0, 0);
        run_q();

        push_instr(LDUR, 0, 3, 0, 0);
        chk("ldur_len", q.size(), 8);
        run_q();
        chk("ldur_mr", sc_mr, 5);
        chk("ldur_rw", sc_rw, 1);

        push_instr(STUR, 2, 1, 0, 0);
        run_q();
        chk("stur_rw", sc_rw, 0);

        push_instr(CBZ, 0, 0, 1, 0);
        chk("cbz_len", q.size(), 3);
        run_q();
        chk("cbz1_pcw", sc_pcw, 2);
        push_instr(CBZ, 0, 0, 0, 0);
        run_q();
        chk("cbz0_pcw", sc_pcw, 1);

        push_instr(ILL, 0, 0, 0, 20);
        push_reset();
        run_q();

        push_instr(ADD, T, 0, 0, 4);
        chk("tmo_len", q.size(), 20);
        push_reset();
        run_q();

        push_instr(ADD, T - 1, 0, 0, 0);
        push_instr(LDUR, 0, T, 0, 3);
        push_reset();
        run_q();

        // Stop mid MEM_WR wait, then pulse rst between edges
        push(0, STUR, 0, 1, o(0, 0, 2'b01, MR | IRW | PCW, 0), "FETCH");
        push(0, STUR, 0, 1, o(0, 0, 2'b11, R2L, 0), "DECODE");
        push(0, STUR, 0, 1, o(0, 1, 2'b10, 0, 0), "EXEC_MEM");
        push(0, STUR, 0, 0, o(0, 0, 0, MW | R2L, 0), "MEM_WR_W");
        push(0, STUR, 0, 0, o(0, 0, 0, MW | R2L, 0), "MEM_WR_W");
        run_q();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_mw", int'(bus.mem_write), 0);
        chk("async_all", int'(actual()), 0);
        push_reset();
        push_instr(STUR, 0, 0, 0, 0);
        run_q();

        push_instr(CBNZ, 0, 0, 0, 3);
        push_reset();
        push_instr(CBNZ, 0, 0, 1, 3);
        push_reset();
        run_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
